// File: rtl/rgmii_link_adapter.sv
// rgmii_link_adapter
// Bridges captured RGMII DDR samples and a MAC-side byte/nibble interface.
// It tracks the PHY in-band link status, gates RX onto the MAC while a link
// is up, and drives TX_CTL/TXD from the MAC through a small TX state machine.
// Optional statistics counters: define RGMII_LINK_ADAPTER_STATS_EN.
// Without it the stat_* outputs are tied to 0.
module rgmii_link_adapter #(
    parameter int STATUS_STABLE = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             phy_rstn,
    input  logic [1:0]       ddr_rx_ctrl,
    input  logic [7:0]       ddr_rx_data,
    output logic [1:0]       ddr_tx_ctrl,
    output logic [7:0]       ddr_tx_data,
    output logic             mac_rx_dv,
    output logic             mac_rx_er,
    output logic [7:0]       mac_rx_data,
    output logic             mac_crs,
    output logic             mac_col,
    input  logic             mac_tx_en,
    input  logic             mac_tx_er,
    input  logic [7:0]       mac_tx_data,
    output logic             link_up_10M,
    output logic             link_up_100M,
    output logic             link_up_1G,
    output logic             link_full_duplex,
    output logic             link_change,
    output logic [CNT_W-1:0] stat_rx_frames,
    output logic [CNT_W-1:0] stat_rx_errors,
    output logic [CNT_W-1:0] stat_tx_aborts
);
    typedef enum logic [1:0] {TX_IDLE, TX_VALID, TX_INVALID, TX_ABORT} tx_state_t;
    typedef enum logic [1:0] {SPD_NONE, SPD_10M, SPD_100M, SPD_1G} speed_t;

    // Run count at which the candidate has been seen STATUS_STABLE times in a row
    localparam logic [7:0] RUN_COMMIT = 8'(STATUS_STABLE - 1);

    logic       rx_dv, rx_er, rx_idle, rx_cext;
    logic       rx_dv_n, rx_er_n;
    logic [3:0] status_q, cand_q;
    logic [7:0] run_q, run_next;
    speed_t     speed, tx_speed_q;
    logic       link_any, half_dup, tx_drop;
    logic [7:0] tx_fmt, rx_fmt;
    tx_state_t  tx_st;

    assign rx_dv   = ddr_rx_ctrl[0];
    assign rx_er   = ddr_rx_ctrl[0] ^ ddr_rx_ctrl[1];
    assign rx_idle = ~rx_dv & ~rx_er;
    // Carrier extension / false carrier seen between frames
    assign rx_cext = rx_er & ~rx_dv & ((ddr_rx_data == 8'hFF) || (ddr_rx_data == 8'h0E));

    // Committed status field [2:0] selects the line rate
    always_comb begin
        speed = SPD_NONE;
        case (status_q[2:0])
            3'b001:  speed = SPD_10M;
            3'b011:  speed = SPD_100M;
            3'b101:  speed = SPD_1G;
            default: speed = SPD_NONE;
        endcase
    end

    assign link_any         = (speed != SPD_NONE);
    assign link_up_10M      = (speed == SPD_10M);
    assign link_up_100M     = (speed == SPD_100M);
    assign link_up_1G       = (speed == SPD_1G);
    assign link_full_duplex = status_q[3] & link_any;
    assign half_dup         = ~status_q[3] & link_any;

    assign rx_dv_n = link_any & rx_dv;
    assign rx_er_n = link_any & rx_er;
    assign rx_fmt  = (speed == SPD_1G) ? ddr_rx_data :
                     link_any          ? {4'h0, ddr_rx_data[3:0]} : 8'h00;
    // 10/100 repeats the nibble so both DDR edges carry the same data
    assign tx_fmt  = (speed == SPD_1G) ? mac_tx_data : {2{mac_tx_data[3:0]}};
    // A link drop shows up as the speed falling to SPD_NONE
    assign tx_drop = (speed != tx_speed_q);

    assign run_next = (ddr_rx_data[3:0] != cand_q) ? 8'd0 :
                      (run_q == 8'hFF)             ? run_q : run_q + 8'd1;

    // In-band status filter: commit a new status after a stable run of idle samples
    always_ff @(posedge clk or negedge phy_rstn) begin
        if (!phy_rstn) begin
            status_q    <= 4'h0;
            cand_q      <= 4'h0;
            run_q       <= 8'd0;
            link_change <= 1'b0;
        end else begin
            link_change <= 1'b0;
            if (rx_idle) begin
                cand_q <= ddr_rx_data[3:0];
                run_q  <= run_next;
                if (run_next >= RUN_COMMIT && ddr_rx_data[3:0] != status_q) begin
                    status_q    <= ddr_rx_data[3:0];
                    link_change <= 1'b1;
                end
            end
        end
    end

    // RX path to the MAC plus carrier sense and collision, one cycle behind the pins
    always_ff @(posedge clk or negedge phy_rstn) begin
        if (!phy_rstn) begin
            mac_rx_dv   <= 1'b0;
            mac_rx_er   <= 1'b0;
            mac_rx_data <= 8'h00;
            mac_crs     <= 1'b0;
            mac_col     <= 1'b0;
        end else begin
            mac_rx_dv   <= rx_dv_n;
            mac_rx_er   <= rx_er_n;
            mac_rx_data <= rx_fmt;
            mac_crs     <= link_any & (rx_dv | rx_cext | (half_dup & (tx_st == TX_VALID)));
            mac_col     <= half_dup & (tx_st == TX_VALID) & (rx_dv | rx_cext);
        end
    end

    // TX state machine with registered TX_CTL/TXD; mac_tx_en low wins over an abort
    always_ff @(posedge clk or negedge phy_rstn) begin
        if (!phy_rstn) begin
            tx_st       <= TX_IDLE;
            tx_speed_q  <= SPD_NONE;
            ddr_tx_ctrl <= 2'b00;
            ddr_tx_data <= 8'h00;
        end else begin
            ddr_tx_ctrl <= 2'b00;
            ddr_tx_data <= 8'h00;
            case (tx_st)
                TX_IDLE: begin
                    if (mac_tx_en) begin
                        if (link_any) begin
                            tx_st       <= TX_VALID;
                            tx_speed_q  <= speed;
                            ddr_tx_ctrl <= {~mac_tx_er, 1'b1};
                            ddr_tx_data <= tx_fmt;
                        end else begin
                            tx_st <= TX_INVALID;
                        end
                    end
                end
                TX_VALID: begin
                    if (!mac_tx_en) begin
                        tx_st <= TX_IDLE;
                    end else if (tx_drop) begin
                        tx_st       <= TX_ABORT;
                        ddr_tx_ctrl <= 2'b01;
                        ddr_tx_data <= ddr_tx_data;
                    end else begin
                        ddr_tx_ctrl <= {~mac_tx_er, 1'b1};
                        ddr_tx_data <= tx_fmt;
                    end
                end
                TX_ABORT: tx_st <= TX_INVALID;
                default: begin
                    if (!mac_tx_en) tx_st <= TX_IDLE;
                end
            endcase
        end
    end

`ifdef RGMII_LINK_ADAPTER_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] rx_frames_q, rx_errors_q, tx_aborts_q;
    logic             frame_err_q;
    logic             abort_entry;

    assign abort_entry = (tx_st == TX_VALID) && mac_tx_en && tx_drop;

    // Frame accounting at the end of each MAC-side frame; counters stick at all-ones
    always_ff @(posedge clk or negedge phy_rstn) begin
        if (!phy_rstn) begin
            rx_frames_q <= '0;
            rx_errors_q <= '0;
            tx_aborts_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            if (rx_dv_n) begin
                if (rx_er_n) frame_err_q <= 1'b1;
            end else if (mac_rx_dv) begin
                if (frame_err_q) begin
                    if (rx_errors_q != CNT_MAX) rx_errors_q <= rx_errors_q + 1'b1;
                end else if (rx_frames_q != CNT_MAX) begin
                    rx_frames_q <= rx_frames_q + 1'b1;
                end
                frame_err_q <= 1'b0;
            end
            if (abort_entry && tx_aborts_q != CNT_MAX) tx_aborts_q <= tx_aborts_q + 1'b1;
        end
    end

    assign stat_rx_frames = rx_frames_q;
    assign stat_rx_errors = rx_errors_q;
    assign stat_tx_aborts = tx_aborts_q;
`else
    assign stat_rx_frames = '0;
    assign stat_rx_errors = '0;
    assign stat_tx_aborts = '0;
`endif

endmodule

// File: tb/tb_rgmii_link_adapter.sv
// tb_rgmii_link_adapter
// Random stimulus per scenario; expected outputs come from a behavioural
// model that applies the adapter's rules to each sampled input cycle.
module tb_rgmii_link_adapter;
    localparam int STATUS_STABLE = 4;
    localparam int CNT_W         = 2;
    localparam int S_IDLE = 0, S_VALID = 1, S_INVALID = 2, S_ABORT = 3;
`ifdef RGMII_LINK_ADAPTER_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             phy_rstn = 1'b1;
    logic [1:0]       ddr_rx_ctrl = 2'b00;
    logic [7:0]       ddr_rx_data = 8'h00;
    logic [1:0]       ddr_tx_ctrl;
    logic [7:0]       ddr_tx_data;
    logic             mac_rx_dv, mac_rx_er, mac_crs, mac_col;
    logic [7:0]       mac_rx_data;
    logic             mac_tx_en = 1'b0, mac_tx_er = 1'b0;
    logic [7:0]       mac_tx_data = 8'h00;
    logic             link_up_10M, link_up_100M, link_up_1G, link_full_duplex, link_change;
    logic [CNT_W-1:0] stat_rx_frames, stat_rx_errors, stat_tx_aborts;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [3:0] m_status;
    logic [3:0] m_hist[$];
    logic       m_change, m_rx_dv, m_rx_er, m_crs, m_col;
    logic [7:0] m_rx_data, m_tx_data;
    logic [1:0] m_tx_ctrl;
    int         m_st, m_tx_spd, m_frames, m_errs, m_aborts;
    bit         m_ferr;

    rgmii_link_adapter #(.STATUS_STABLE(STATUS_STABLE), .CNT_W(CNT_W)) dut (
        .clk(clk), .phy_rstn(phy_rstn),
        .ddr_rx_ctrl(ddr_rx_ctrl), .ddr_rx_data(ddr_rx_data),
        .ddr_tx_ctrl(ddr_tx_ctrl), .ddr_tx_data(ddr_tx_data),
        .mac_rx_dv(mac_rx_dv), .mac_rx_er(mac_rx_er), .mac_rx_data(mac_rx_data),
        .mac_crs(mac_crs), .mac_col(mac_col),
        .mac_tx_en(mac_tx_en), .mac_tx_er(mac_tx_er), .mac_tx_data(mac_tx_data),
        .link_up_10M(link_up_10M), .link_up_100M(link_up_100M), .link_up_1G(link_up_1G),
        .link_full_duplex(link_full_duplex), .link_change(link_change),
        .stat_rx_frames(stat_rx_frames), .stat_rx_errors(stat_rx_errors),
        .stat_tx_aborts(stat_tx_aborts)
    );

    always #5 clk = ~clk;

    // 0 = no link, 1 = 10M, 2 = 100M, 3 = 1G
    function automatic int speed_of(input logic [3:0] s);
        case (s[2:0])
            3'b001:  return 1;
            3'b011:  return 2;
            3'b101:  return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] exp_stat(input int n);
        int mx;
        mx = (1 << CNT_W) - 1;
        if (!STATS_ON) return '0;
        if (n > mx) n = mx;
        return n[CNT_W-1:0];
    endfunction

    function automatic logic [4:0] exp_link();
        int spd;
        spd = speed_of(m_status);
        return {spd == 1, spd == 2, spd == 3, m_status[3] && spd != 0, m_change};
    endfunction

    task automatic model_reset();
        m_status = 4'h0;
        m_hist.delete();
        m_hist.push_back(4'h0);
        m_change = 0; m_rx_dv = 0; m_rx_er = 0; m_rx_data = 0; m_crs = 0; m_col = 0;
        m_st = S_IDLE; m_tx_spd = 0; m_tx_ctrl = 0; m_tx_data = 0;
        m_frames = 0; m_errs = 0; m_aborts = 0; m_ferr = 0;
    endtask

    // Apply one sampled cycle of inputs to the model
    task automatic model_step();
        int spd;
        bit lk, fd, dv, er, cext, valid, all_eq;
        spd   = speed_of(m_status);
        lk    = (spd != 0);
        fd    = m_status[3] && lk;
        dv    = ddr_rx_ctrl[0];
        er    = ddr_rx_ctrl[0] ^ ddr_rx_ctrl[1];
        cext  = er && !dv && (ddr_rx_data == 8'hFF || ddr_rx_data == 8'h0E);
        valid = (m_st == S_VALID);
        if (lk && dv) begin
            if (er) m_ferr = 1;
        end else if (m_rx_dv) begin
            if (m_ferr) m_errs++; else m_frames++;
            m_ferr = 0;
        end
        m_rx_dv   = lk && dv;
        m_rx_er   = lk && er;
        m_rx_data = (spd == 3) ? ddr_rx_data : (lk ? {4'h0, ddr_rx_data[3:0]} : 8'h00);
        m_crs     = lk && (dv || cext || (!fd && valid));
        m_col     = lk && !fd && valid && (dv || cext);
        case (m_st)
            S_IDLE:  if (mac_tx_en) begin m_st = lk ? S_VALID : S_INVALID; m_tx_spd = spd; end
            S_VALID: begin
                if (!mac_tx_en) m_st = S_IDLE;
                else if (spd != m_tx_spd) begin m_st = S_ABORT; m_aborts++; end
            end
            S_ABORT: m_st = S_INVALID;
            default: if (!mac_tx_en) m_st = S_IDLE;
        endcase
        if (m_st == S_VALID) begin
            m_tx_ctrl = {1'b1 ^ mac_tx_er, 1'b1};
            m_tx_data = (spd == 3) ? mac_tx_data : {mac_tx_data[3:0], mac_tx_data[3:0]};
        end else if (m_st == S_ABORT) begin
            m_tx_ctrl = 2'b01;
        end else begin
            m_tx_ctrl = 2'b00;
            m_tx_data = 8'h00;
        end
        m_change = 0;
        if (ddr_rx_ctrl == 2'b00) begin
            m_hist.push_back(ddr_rx_data[3:0]);
            if (m_hist.size() > STATUS_STABLE) void'(m_hist.pop_front());
            all_eq = (m_hist.size() == STATUS_STABLE);
            foreach (m_hist[i]) if (m_hist[i] != ddr_rx_data[3:0]) all_eq = 0;
            if (all_eq && ddr_rx_data[3:0] != m_status) begin
                m_status = ddr_rx_data[3:0];
                m_change = 1;
            end
        end
    endtask

    // Drive RX pins, take one clock, then sit 1 time unit past the edge
    task automatic step(input logic [1:0] c, input logic [7:0] d);
        ddr_rx_ctrl = c;
        ddr_rx_data = d;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic hold(input logic [3:0] s, input int n);
        for (int i = 0; i < n; i++) step(2'b00, {4'($urandom), s});
    endtask

    task automatic test_reset();
        #3 phy_rstn = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({ddr_tx_ctrl, ddr_tx_data} !== 10'd0) begin
            errors++; $display("FAIL reset_tx: got %h expected 0", {ddr_tx_ctrl, ddr_tx_data});
        end
        checks++;
        if ({mac_rx_dv, mac_rx_er, mac_rx_data, mac_crs, mac_col} !== 12'd0) begin
            errors++; $display("FAIL reset_rx: got %h expected 0", {mac_rx_dv, mac_rx_er, mac_rx_data, mac_crs, mac_col});
        end
        checks++;
        if ({link_up_10M, link_up_100M, link_up_1G, link_full_duplex, link_change,
             stat_rx_frames, stat_rx_errors, stat_tx_aborts} !== '0) begin
            errors++; $display("FAIL reset_link_stat: got nonzero link/stat outputs");
        end
        @(posedge clk);
        #1 phy_rstn = 1'b1;
    endtask

    task automatic test_status_commit();
        int pulses;
        logic [3:0] vals [0:7];
        logic [3:0] v;
        mac_tx_en = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin step(2'b00, {4'($urandom), 4'hB}); pulses += int'(link_change); end
        step(2'b00, {4'($urandom), 4'h3});
        pulses += int'(link_change);
        checks++;
        if (pulses != 0 || {link_up_10M, link_up_100M, link_up_1G} !== 3'b000) begin
            errors++; $display("FAIL no_commit_short_run: pulses %0d link %b expected 0/000", pulses, {link_up_10M, link_up_100M, link_up_1G});
        end
        for (int i = 0; i < 4; i++) begin step(2'b00, {4'($urandom), 4'hB}); pulses += int'(link_change); end
        // 4'hB: link bit set, speed field 01, full duplex -> 100M full duplex
        checks++;
        if ({link_up_10M, link_up_100M, link_up_1G, link_full_duplex, link_change} !== 5'b01011) begin
            errors++; $display("FAIL commit_B: got %b expected 01011", {link_up_10M, link_up_100M, link_up_1G, link_full_duplex, link_change});
        end
        step(2'b00, {4'($urandom), 4'hB});
        pulses += int'(link_change);
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL commit_single_pulse: got %0d pulses expected 1", pulses);
        end
        vals = '{4'h1, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'h0, 4'h7};
        for (int r = 0; r < 25; r++) begin
            v = vals[$urandom_range(0, 7)];
            for (int k = $urandom_range(1, 6); k > 0; k--) begin
                if ($urandom_range(0, 9) < 7) step(2'b00, {4'($urandom), v});
                else step(2'($urandom_range(1, 3)), 8'($urandom));
                checks++;
                if ({link_up_10M, link_up_100M, link_up_1G, link_full_duplex, link_change} !== exp_link()) begin
                    errors++; $display("FAIL status_random: got %b expected %b", {link_up_10M, link_up_100M, link_up_1G, link_full_duplex, link_change}, exp_link());
                end
            end
        end
        hold(4'hB, STATUS_STABLE);
    endtask

    task automatic test_rx_frame();
        logic [3:0] prev_nib;
        logic [7:0] d;
        int len;
        prev_nib = 4'h0;
        for (int i = 0; i < 64; i++) begin
            d = 8'($urandom);
            step(2'b11, d);
            if (i > 0) begin
                checks++;
                if (mac_rx_data[3:0] !== d[3:0] || mac_rx_data[7:4] !== 4'h0 || prev_nib === 4'hx) begin
                    errors++; $display("FAIL rx_nibble: got %h expected %h", mac_rx_data, {4'h0, d[3:0]});
                end
            end
            prev_nib = d[3:0];
            checks++;
            if ({mac_rx_dv, mac_rx_er, mac_crs, mac_col} !== 4'b1010) begin
                errors++; $display("FAIL rx_frame_ctl: dv/er/crs/col got %b expected 1010", {mac_rx_dv, mac_rx_er, mac_crs, mac_col});
            end
        end
        step(2'b00, {4'($urandom), 4'hB});
        checks++;
        if (mac_rx_dv !== 1'b0 || stat_rx_frames !== exp_stat(m_frames)) begin
            errors++; $display("FAIL rx_frame_count: dv %b frames %0d expected 0/%0d", mac_rx_dv, stat_rx_frames, exp_stat(m_frames));
        end
        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(4, 20);
            for (int i = 0; i < len; i++) begin
                step(($urandom_range(0, 9) == 0) ? 2'b01 : 2'b11, 8'($urandom));
                checks++;
                if ({mac_rx_dv, mac_rx_er, mac_rx_data, mac_crs, mac_col} !== {m_rx_dv, m_rx_er, m_rx_data, m_crs, m_col}) begin
                    errors++; $display("FAIL rx_random: got %h expected %h", {mac_rx_dv, mac_rx_er, mac_rx_data, mac_crs, mac_col}, {m_rx_dv, m_rx_er, m_rx_data, m_crs, m_col});
                end
            end
            step(2'b10, $urandom_range(0, 1) ? 8'hFF : 8'h0E);
            checks++;
            if ({mac_rx_dv, mac_crs} !== {m_rx_dv, m_crs}) begin
                errors++; $display("FAIL rx_carrier_ext: dv/crs got %b expected %b", {mac_rx_dv, mac_crs}, {m_rx_dv, m_crs});
            end
            hold(4'hB, $urandom_range(1, 3));
        end
        checks++;
        if ({stat_rx_frames, stat_rx_errors} !== {exp_stat(m_frames), exp_stat(m_errs)}) begin
            errors++; $display("FAIL rx_stats: got %h/%h expected %h/%h", stat_rx_frames, stat_rx_errors, exp_stat(m_frames), exp_stat(m_errs));
        end
    endtask

    task automatic test_tx_1g();
        hold(4'hD, STATUS_STABLE);
        mac_tx_en = 1'b1; mac_tx_er = 1'b0; mac_tx_data = 8'hA5;
        step(2'b00, {4'($urandom), 4'hD});
        checks++;
        if (ddr_tx_data !== 8'hA5 || ddr_tx_ctrl !== 2'b11) begin
            errors++; $display("FAIL tx_1g_A5: got %h/%b expected a5/11", ddr_tx_data, ddr_tx_ctrl);
        end
        mac_tx_er = 1'b1;
        step(2'b00, {4'($urandom), 4'hD});
        checks++;
        if (ddr_tx_ctrl !== 2'b01) begin
            errors++; $display("FAIL tx_1g_er: got %b expected 01", ddr_tx_ctrl);
        end
        for (int i = 0; i < 20; i++) begin
            mac_tx_er = ($urandom_range(0, 4) == 0);
            mac_tx_data = 8'($urandom);
            step(2'b00, {4'($urandom), 4'hD});
            checks++;
            if ({ddr_tx_ctrl, ddr_tx_data} !== {m_tx_ctrl, m_tx_data}) begin
                errors++; $display("FAIL tx_1g_random: got %h expected %h", {ddr_tx_ctrl, ddr_tx_data}, {m_tx_ctrl, m_tx_data});
            end
        end
        mac_tx_en = 1'b0; mac_tx_er = 1'b0;
        step(2'b00, {4'($urandom), 4'hD});
        checks++;
        if ({ddr_tx_ctrl, ddr_tx_data} !== 10'd0) begin
            errors++; $display("FAIL tx_1g_end: got %h expected 0", {ddr_tx_ctrl, ddr_tx_data});
        end
    endtask

    task automatic test_tx_abort();
        int abort_cycles;
        abort_cycles = 0;
        mac_tx_en = 1'b1;
        for (int i = 0; i < 2; i++) begin mac_tx_data = 8'($urandom); step(2'b00, {4'($urandom), 4'hD}); end
        for (int i = 0; i < STATUS_STABLE + 3; i++) begin
            mac_tx_data = 8'($urandom);
            step(2'b00, {4'($urandom), 4'h0});
            if (ddr_tx_ctrl === 2'b01) abort_cycles++;
            checks++;
            if ({ddr_tx_ctrl, ddr_tx_data} !== {m_tx_ctrl, m_tx_data}) begin
                errors++; $display("FAIL tx_abort_seq: got %h expected %h", {ddr_tx_ctrl, ddr_tx_data}, {m_tx_ctrl, m_tx_data});
            end
        end
        checks++;
        if (abort_cycles != 1 || ddr_tx_ctrl !== 2'b00) begin
            errors++; $display("FAIL tx_abort_once: got %0d abort cycles ctrl %b expected 1/00", abort_cycles, ddr_tx_ctrl);
        end
        mac_tx_en = 1'b0;
        step(2'b00, 8'h00);
        checks++;
        if (stat_tx_aborts !== exp_stat(m_aborts)) begin
            errors++; $display("FAIL tx_abort_stat: got %0d expected %0d", stat_tx_aborts, exp_stat(m_aborts));
        end
    endtask

    task automatic test_half_duplex();
        bit seen_col, seen_crs;
        logic [7:0] td;
        seen_col = 0; seen_crs = 0;
        hold(4'h1, STATUS_STABLE);
        mac_tx_en = 1'b1; mac_tx_er = 1'b0;
        for (int i = 0; i < 6; i++) begin
            td = 8'($urandom);
            mac_tx_data = td;
            step(2'b11, 8'($urandom));
            seen_col |= (mac_col === 1'b1);
            seen_crs |= (mac_crs === 1'b1);
            checks++;
            if ({ddr_tx_ctrl, ddr_tx_data, mac_crs, mac_col} !== {2'b11, td[3:0], td[3:0], m_crs, m_col}) begin
                errors++; $display("FAIL hd_tx_col: got %h expected %h", {ddr_tx_ctrl, ddr_tx_data, mac_crs, mac_col}, {2'b11, td[3:0], td[3:0], m_crs, m_col});
            end
        end
        checks++;
        if (!seen_col || !seen_crs) begin
            errors++; $display("FAIL hd_collision_seen: col %0d crs %0d expected 1/1", seen_col, seen_crs);
        end
        mac_tx_en = 1'b0;
        step(2'b00, 8'h01);
        hold(4'h0, STATUS_STABLE);
        mac_tx_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mac_tx_data = 8'($urandom);
            step(2'b00, 8'h00);
            checks++;
            if (ddr_tx_ctrl !== 2'b00 || ddr_tx_ctrl !== m_tx_ctrl) begin
                errors++; $display("FAIL tx_no_link: got %b expected 00", ddr_tx_ctrl);
            end
        end
        mac_tx_en = 1'b0;
        step(2'b00, 8'h00);
    endtask

    task automatic test_rx_errors_sat();
        int errpos;
        hold(4'hB, STATUS_STABLE);
        for (int f = 0; f < 5; f++) begin
            errpos = $urandom_range(0, 5);
            for (int i = 0; i < 6; i++) begin
                step((i == errpos) ? 2'b01 : 2'b11, 8'($urandom));
                checks++;
                if ({mac_rx_dv, mac_rx_er} !== {1'b1, i == errpos}) begin
                    errors++; $display("FAIL rx_err_flag: got %b expected %b", {mac_rx_dv, mac_rx_er}, {1'b1, i == errpos});
                end
            end
            hold(4'hB, 2);
        end
        checks++;
        if (stat_rx_errors !== exp_stat(m_errs) || (STATS_ON && stat_rx_errors !== 2'b11)) begin
            errors++; $display("FAIL rx_err_saturate: got %0d expected %0d", stat_rx_errors, exp_stat(m_errs));
        end
    endtask

    task automatic test_reset_midframe();
        hold(4'hD, STATUS_STABLE);
        mac_tx_en = 1'b1; mac_tx_er = 1'b0;
        for (int i = 0; i < 2; i++) begin mac_tx_data = 8'($urandom); step(2'b11, 8'($urandom)); end
        checks++;
        if ({ddr_tx_ctrl, mac_rx_dv} !== 3'b111) begin
            errors++; $display("FAIL midframe_active: got %b expected 111", {ddr_tx_ctrl, mac_rx_dv});
        end
        #3 phy_rstn = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({ddr_tx_ctrl, ddr_tx_data} !== 10'd0) begin
            errors++; $display("FAIL midreset_tx: got %h expected 0", {ddr_tx_ctrl, ddr_tx_data});
        end
        checks++;
        if ({mac_rx_dv, mac_rx_er, mac_rx_data, mac_crs, mac_col, link_up_10M, link_up_100M,
             link_up_1G, link_full_duplex, link_change, stat_rx_frames, stat_rx_errors, stat_tx_aborts} !== '0) begin
            errors++; $display("FAIL midreset_outputs: got nonzero rx/link/stat outputs");
        end
        @(posedge clk);
        #1 phy_rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 8'h00);
            checks++;
            if (ddr_tx_ctrl !== 2'b00 || ddr_tx_ctrl !== m_tx_ctrl) begin
                errors++; $display("FAIL post_reset_tx: got %b expected 00", ddr_tx_ctrl);
            end
        end
        mac_tx_en = 1'b0;
        step(2'b00, 8'h00);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_status_commit();
        test_rx_frame();
        test_tx_1g();
        test_tx_abort();
        test_half_duplex();
        test_rx_errors_sat();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
